// File: rtl/period_bcd_converter.sv
// Converts a latched binary millisecond count to packed BCD, one bit per clock (double dabble).
// Build option BCD_SATURATE_EN: an out-of-range count displays all nines instead of the truncated value.
module period_bcd_converter #(
   parameter int BIN_N  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [BIN_N-1:0]      bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  overflow_o
);

   // state | meaning
   // IDLE  | waiting for start_i; bcd_o/overflow_o hold the last result
   // OP    | one shift-add-3 step per cycle, BIN_N cycles
   // DONE  | single cycle, done_o high, result valid
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP   = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(BIN_N + 1);

   state_t            state_q, state_d;
   logic [BIN_N-1:0]  shift_q, shift_d;
   logic [BW-1:0]     work_q, work_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic              ovfo_q, ovfo_d;

   logic [BW-1:0]     adj;
   logic [BW-1:0]     work_sh;
   logic              ovf_nx;

   always_comb begin
      adj = work_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (adj[4*d +: 4] >= 4'd5) begin
            adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
         end
      end
      work_sh = {adj[BW-2:0], shift_q[BIN_N-1]};
      // a 1 leaving the top digit means the count needs one more decimal digit
      ovf_nx  = ovf_q | adj[BW-1];
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      bcd_d   = bcd_q;
      ovfo_d  = ovfo_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               shift_d = bin_i;
               work_d  = '0;
               cnt_d   = CW'(BIN_N);
               ovf_d   = 1'b0;
               state_d = OP;
            end
         end
         OP: begin
            work_d  = work_sh;
            shift_d = {shift_q[BIN_N-2:0], 1'b0};
            ovf_d   = ovf_nx;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
               ovfo_d  = ovf_nx;
`ifdef BCD_SATURATE_EN
               bcd_d   = ovf_nx ? {DIGITS{4'h9}} : work_sh;
`else
               bcd_d   = work_sh;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         shift_q <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         bcd_q   <= '0;
         ovfo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         bcd_q   <= bcd_d;
         ovfo_q  <= ovfo_d;
      end
   end

   assign busy_o     = (state_q == OP);
   assign done_o     = (state_q == DONE);
   assign bcd_o      = bcd_q;
   assign overflow_o = ovfo_q;

endmodule

// File: tb/tb_period_bcd_converter.sv
// Directed self-checking bench for period_bcd_converter (BIN_N=14, DIGITS=4).
module tb_period_bcd_converter;

   localparam int BIN_N  = 14;
   localparam int DIGITS = 4;
   localparam int LAT    = 14;   // edges from the accept edge to the edge entering DONE

   logic               clk_i = 1'b0;
   logic               reset_i;
   logic               start_i;
   logic [BIN_N-1:0]   bin_i;
   logic               busy_o;
   logic               done_o;
   logic [15:0]        bcd_o;
   logic               overflow_o;

   int checks = 0;
   int errors = 0;

   period_bcd_converter #(.BIN_N(BIN_N), .DIGITS(DIGITS)) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .start_i    (start_i),
      .bin_i      (bin_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .bcd_o      (bcd_o),
      .overflow_o (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   // Drive a one-cycle start pulse; returns #1 after the accept edge.
   task automatic start_conv(input logic [BIN_N-1:0] v);
      @(posedge clk_i); #1;
      start_i = 1'b1;
      bin_i   = v;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   // Counts edges until done_o is seen (-1 on timeout) and cycles with busy_o high.
   task automatic wait_done(output int n, output int busy_n);
      n = 0;
      busy_n = 0;
      while (!done_o && n < 40) begin
         if (busy_o) busy_n++;
         @(posedge clk_i); #1;
         n++;
      end
      if (!done_o) n = -1;
   endtask

   task automatic test_reset;
      reset_i = 1'b1;
      start_i = 1'b0;
      bin_i   = '0;
      #12;
      checks++;
      if (bcd_o !== 16'h0000 || overflow_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got bcd=%h ovf=%b busy=%b done=%b, expected 0000 0 0 0",
                  bcd_o, overflow_o, busy_o, done_o);
      end
      @(negedge clk_i);
      reset_i = 1'b0;
   endtask

   task automatic test_zero;
      int n, b;
      start_conv(14'd0);
      wait_done(n, b);
      checks++;
      if (n !== LAT) begin
         errors++;
         $display("FAIL zero_latency: got %0d edges, expected %0d", n, LAT);
      end
      checks++;
      if (b !== BIN_N) begin
         errors++;
         $display("FAIL zero_busy_cycles: got %0d, expected %0d", b, BIN_N);
      end
      checks++;
      if (bcd_o !== 16'h0000 || overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL zero_result: got %h ovf=%b, expected 0000 ovf=0", bcd_o, overflow_o);
      end
      @(posedge clk_i); #1;
      checks++;
      if (done_o !== 1'b0) begin
         errors++;
         $display("FAIL zero_done_pulse: done_o got %b, expected 0", done_o);
      end
   endtask

   task automatic test_hold;
      int n, b;
      start_conv(14'd1234);
      wait_done(n, b);
      checks++;
      if (bcd_o !== 16'h1234 || overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL conv_1234: got %h ovf=%b, expected 1234 ovf=0", bcd_o, overflow_o);
      end
      start_conv(14'd9999);
      repeat (5) @(posedge clk_i);
      #1;
      checks++;
      if (bcd_o !== 16'h1234) begin
         errors++;
         $display("FAIL hold_during_op: got %h, expected 1234", bcd_o);
      end
      wait_done(n, b);
      checks++;
      if (bcd_o !== 16'h9999 || overflow_o !== 1'b0 || n !== LAT - 5) begin
         errors++;
         $display("FAIL conv_9999: got %h ovf=%b n=%0d, expected 9999 ovf=0 n=%0d",
                  bcd_o, overflow_o, n, LAT - 5);
      end
   endtask

   task automatic test_overflow;
      int n, b;
      logic [15:0] exp_a, exp_b;
`ifdef BCD_SATURATE_EN
      exp_a = 16'h9999;
      exp_b = 16'h9999;
`else
      exp_a = 16'h0000;
      exp_b = 16'h6383;
`endif
      start_conv(14'd10000);
      wait_done(n, b);
      checks++;
      if (bcd_o !== exp_a || overflow_o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_10000: got %h ovf=%b, expected %h ovf=1", bcd_o, overflow_o, exp_a);
      end
      start_conv(14'd16383);
      wait_done(n, b);
      checks++;
      if (bcd_o !== exp_b || overflow_o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_16383: got %h ovf=%b, expected %h ovf=1", bcd_o, overflow_o, exp_b);
      end
      start_conv(14'd1);
      wait_done(n, b);
      checks++;
      if (bcd_o !== 16'h0001 || overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clears: got %h ovf=%b, expected 0001 ovf=0", bcd_o, overflow_o);
      end
   endtask

   task automatic test_back_to_back;
      int n, b;
      start_conv(14'd42);
      repeat (4) @(posedge clk_i);
      #1;
      start_i = 1'b1;            // cycle 5, mid-OP: must be ignored
      bin_i   = 14'd77;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      wait_done(n, b);
      checks++;
      if (n !== LAT - 5 || bcd_o !== 16'h0042) begin
         errors++;
         $display("FAIL ignore_mid_op: got %h n=%0d, expected 0042 n=%0d", bcd_o, n, LAT - 5);
      end
      start_i = 1'b1;            // held through DONE and the following IDLE cycle
      bin_i   = 14'd77;
      @(posedge clk_i); #1;
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL ignore_in_done: got busy=%b done=%b, expected 0 0", busy_o, done_o);
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
      wait_done(n, b);
      checks++;
      if (n !== LAT || bcd_o !== 16'h0077) begin
         errors++;
         $display("FAIL back_to_back_77: got %h n=%0d, expected 0077 n=%0d", bcd_o, n, LAT);
      end
   endtask

   task automatic test_reset_mid_op;
      int n, b;
      int seen;
      start_conv(14'd500);
      wait_done(n, b);
      checks++;
      if (bcd_o !== 16'h0500) begin
         errors++;
         $display("FAIL conv_500: got %h, expected 0500", bcd_o);
      end
      start_conv(14'd321);
      repeat (6) @(posedge clk_i);
      #1;
      reset_i = 1'b1;
      #1;
      checks++;
      if (bcd_o !== 16'h0000 || overflow_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_op: got bcd=%h ovf=%b busy=%b done=%b, expected 0000 0 0 0",
                  bcd_o, overflow_o, busy_o, done_o);
      end
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk_i); #1;
         if (done_o || busy_o) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL no_done_after_reset: got %0d active cycles, expected 0", seen);
      end
      start_conv(14'd321);
      wait_done(n, b);
      checks++;
      if (bcd_o !== 16'h0321 || n !== LAT) begin
         errors++;
         $display("FAIL conv_321: got %h n=%0d, expected 0321 n=%0d", bcd_o, n, LAT);
      end
   endtask

   task automatic test_bin_stable;
      int n;
      start_conv(14'd808);
      n = 0;
      while (!done_o && n < 40) begin
         bin_i = 14'($urandom_range(0, 16383));
         @(posedge clk_i); #1;
         n++;
      end
      checks++;
      if (!done_o || bcd_o !== 16'h0808 || overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL bin_ignored_in_op: got %h ovf=%b done=%b, expected 0808 ovf=0 done=1",
                  bcd_o, overflow_o, done_o);
      end
   endtask

   initial begin
      test_reset;
      test_zero;
      test_hold;
      test_overflow;
      test_back_to_back;
      test_reset_mid_op;
      test_bin_stable;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
